fifo_1r1w_flow: RTL and testbench
=================================

FIFO_1R1W_FLOW -- requirements
Module: fifo_1r1w_flow

Interface
REQ-001 SHALL have parameter width_p, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter depth_log2_p, default 4, log2 of storage depth; depth = 2**depth_log2_p (depth_log2_p >= 1).
REQ-003 SHALL have parameter almost_full_p, default 12, occupancy at or above which almost_full_o asserts (1..depth).
REQ-004 SHALL have parameter almost_empty_p, default 2, occupancy at or below which almost_empty_o asserts (0..depth-1).
REQ-005 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush_i  input  1  synchronous discard of all stored entries.
REQ-008 SHALL have port data_i  input  width_p  write data.
REQ-009 SHALL have port valid_i  input  1  write request.
REQ-010 SHALL have port ready_o  output  1  FIFO can accept a word.
REQ-011 SHALL have port valid_o  output  1  data_o holds the oldest stored word.
REQ-012 SHALL have port data_o  output  width_p  read data.
REQ-013 SHALL have port ready_i  input  1  consumer accepts data_o.
REQ-014 SHALL have port count_o  output  depth_log2_p+1  current occupancy, 0..depth.
REQ-015 SHALL have port almost_full_o  output  1  count_o >= almost_full_p.
REQ-016 SHALL have port almost_empty_o  output  1  count_o <= almost_empty_p.
REQ-017 SHALL have port overflow_o  output  1  sticky write-while-full flag (present only with FIFO_1R1W_FLOW_OVF_EN).

Function
REQ-018 SHALL perform a write when valid_i & ready_o, and a read when valid_o & ready_i.
REQ-019 SHALL drive ready_o = (count_o != depth) and valid_o = (count_o != 0), both from registered state only; neither depends combinationally on valid_i or ready_i.
REQ-020 SHALL present a word written in cycle N on data_o with valid_o=1 in cycle N+1 when the FIFO was empty (1-cycle latency, write-to-read bypass past the synchronous-read RAM).
REQ-021 SHALL deliver words in strict write order with no loss or duplication.
REQ-022 SHALL update count_o by +1 on write only, -1 on read only, and leave it unchanged on simultaneous read and write.
REQ-023 SHALL, at full (count=depth), reject writes even if a read occurs the same cycle; the freed slot is usable next cycle.
REQ-024 SHALL wrap read and write pointers modulo depth using an extra MSB to distinguish full from empty.
REQ-025 SHALL, on flush_i=1, set count_o to 0 and pointers equal next cycle; flush overrides any write or read in the same cycle (write dropped, read not counted).
REQ-026 SHALL hold data_o stable while valid_o=1 and ready_i=0.
REQ-027 SHALL treat data_o as don't-care while valid_o=0.

Reset
REQ-028 SHALL, with reset_i=1 at a clock edge, clear pointers and count regardless of other inputs; reset overrides flush, read and write.
REQ-029 SHALL present after reset: count_o=0, valid_o=0, ready_o=1, almost_empty_o=1, almost_full_o=0, overflow_o=0.
REQ-030 SHALL not require RAM contents to be cleared by reset.

Configuration
REQ-031 SHALL, with macro FIFO_1R1W_FLOW_OVF_EN defined, provide overflow_o, set to 1 the cycle after any cycle with valid_i=1 and ready_o=0, held until reset_i (flush_i does not clear it).
REQ-032 SHALL, without FIFO_1R1W_FLOW_OVF_EN, omit overflow_o and its logic entirely; all other behaviour identical.

Verification (width_p=8, depth_log2_p=2, almost_full_p=3, almost_empty_p=1)
REQ-033 SHALL cover: reset, write 0xA5 one cycle with ready_i=0 -> next cycle valid_o=1, data_o=0xA5, count_o=1, almost_empty_o=1.
REQ-034 SHALL cover: write 0x01..0x04 back-to-back, ready_i=0 -> count_o=4, ready_o=0, almost_full_o=1 from the third write on; fifth write 0x05 ignored.
REQ-035 SHALL cover: at full, valid_i=1 data 0x05 and ready_i=1 same cycle -> 0x01 read, 0x05 dropped, count_o=3; next-cycle write of 0x05 accepted, reads yield 0x02,0x03,0x04,0x05.
REQ-036 SHALL cover: count_o=2, continuous write and read for 10 cycles with incrementing data -> count_o stays 2, output order matches input through pointer wrap.
REQ-037 SHALL cover: count_o=3, flush_i=1 with valid_i=1 -> next cycle count_o=0, valid_o=0, ready_o=1; subsequent write 0x7E read back as 0x7E.
REQ-038 SHALL cover (FIFO_1R1W_FLOW_OVF_EN): write while full -> overflow_o=1 next cycle, stays 1 after flush_i, clears to 0 only after reset_i.

Source files
------------

// File: rtl/fifo_1r1w_flow.sv
// fifo_1r1w_flow
// Single-clock, one-read/one-write FIFO with valid/ready flow control on both
// sides, a synchronous flush, occupancy output and almost-full/almost-empty flags.
// Storage is a RAM with synchronous read. The output word is registered, and a
// bypass carries a write into an empty FIFO straight to data_o on the next cycle.
//
// Optional feature: define FIFO_1R1W_FLOW_OVF_EN to add the sticky overflow_o flag.
//
// Parameters:
//   width_p        data word width
//   depth_log2_p   log2 of storage depth
//   almost_full_p  almost_full_o asserts when count_o >= this value
//   almost_empty_p almost_empty_o asserts when count_o <= this value
// Ports:
//   clk_i          clock, rising edge
//   reset_i        synchronous active-high reset (pointers, count, overflow)
//   flush_i        synchronous discard of all stored entries
//   data_i/valid_i/ready_o   write side
//   data_o/valid_o/ready_i   read side
//   count_o        current occupancy 0..depth
//   almost_full_o, almost_empty_o   occupancy threshold flags
//   overflow_o     sticky write-while-full flag (FIFO_1R1W_FLOW_OVF_EN only)
module fifo_1r1w_flow #(
    parameter int width_p        = 8,
    parameter int depth_log2_p   = 4,
    parameter int almost_full_p  = 12,
    parameter int almost_empty_p = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flush_i,
    input  logic [width_p-1:0]      data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    ready_i,
    output logic [depth_log2_p:0]   count_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o
`ifdef FIFO_1R1W_FLOW_OVF_EN
    ,
    output logic                    overflow_o
`endif
);

    localparam int PW = depth_log2_p + 1;
    localparam int DEPTH = 1 << depth_log2_p;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(almost_full_p);
    localparam logic [PW-1:0] AE_C    = PW'(almost_empty_p);

    logic [width_p-1:0] mem_q [DEPTH];

    // Pointers carry one extra MSB so full (MSBs differ) and empty (equal) are distinct.
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      remain;
    logic [width_p-1:0] dout_q, dout_d;
    logic               do_write, do_read;

    // Occupancy and handshake outputs come from registered pointers only.
    assign count_o        = wr_ptr_q - rd_ptr_q;
    assign ready_o        = (count_o != DEPTH_C);
    assign valid_o        = (count_o != '0);
    assign almost_full_o  = (count_o >= AF_C);
    assign almost_empty_o = (count_o <= AE_C);
    assign data_o         = dout_q;

    // Flush cancels both transfers in its cycle.
    assign do_write = valid_i & ready_o & ~flush_i;
    assign do_read  = valid_o & ready_i & ~flush_i;

    // Entries that stay stored after this cycle's read, excluding this cycle's write.
    assign remain = count_o - PW'(do_read);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_read) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
        // Registered read of the next head entry. If nothing older survives,
        // the head is the word being written now, which has not reached the RAM yet.
        if (remain == '0) begin
            if (do_write) begin
                dout_d = data_i;
            end
        end else begin
            dout_d = mem_q[rd_ptr_d[depth_log2_p-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Data path: storage and output register are not reset.
    always_ff @(posedge clk_i) begin
        if (do_write && !reset_i) begin
            mem_q[wr_ptr_q[depth_log2_p-1:0]] <= data_i;
        end
        dout_q <= dout_d;
    end

`ifdef FIFO_1R1W_FLOW_OVF_EN
    logic overflow_q;

    // Any write attempt while full sets the flag; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overflow_q <= 1'b0;
        end else if (valid_i && !ready_o) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_fifo_1r1w_flow.sv
// tb_fifo_1r1w_flow
// Bench for fifo_1r1w_flow at width_p=8, depth_log2_p=2, almost_full_p=3,
// almost_empty_p=1. A table of per-cycle vectors gives inputs and the expected
// registered outputs after the clock edge; a queue scoreboard checks read data
// order. Hand-written sequences cover streaming through pointer wrap, a
// randomized run and, with FIFO_1R1W_FLOW_OVF_EN, the sticky overflow flag.
module tb_fifo_1r1w_flow;

    logic       clk_i;
    logic       reset_i;
    logic       flush_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       valid_o;
    logic [7:0] data_o;
    logic       ready_i;
    logic [2:0] count_o;
    logic       almost_full_o;
    logic       almost_empty_o;
`ifdef FIFO_1R1W_FLOW_OVF_EN
    logic       overflow_o;
`endif

    fifo_1r1w_flow #(
        .width_p(8),
        .depth_log2_p(2),
        .almost_full_p(3),
        .almost_empty_p(1)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .flush_i(flush_i),
        .data_i(data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .data_o(data_o),
        .ready_i(ready_i),
        .count_o(count_o),
        .almost_full_o(almost_full_o),
        .almost_empty_o(almost_empty_o)
`ifdef FIFO_1R1W_FLOW_OVF_EN
        ,
        .overflow_o(overflow_o)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic       rst;
        logic       fl;
        logic       v;
        logic [7:0] d;
        logic       rd;
        logic [2:0] c;
        logic       vo;
        logic       ro;
        logic       af;
        logic       ae;
        logic       cd;
        logic [7:0] dout;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sbq[$];
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic add(input logic rst, fl, v, input logic [7:0] d, input logic rd,
                       input logic [2:0] c, input logic vo, ro, af, ae, cd,
                       input logic [7:0] dout);
        vec_t t;
        t.rst = rst; t.fl = fl; t.v = v; t.d = d; t.rd = rd;
        t.c = c; t.vo = vo; t.ro = ro; t.af = af; t.ae = ae; t.cd = cd; t.dout = dout;
        vecs.push_back(t);
    endtask

    // Drive one cycle; at the falling edge score the transfers that the
    // upcoming rising edge will perform; return 1 time unit after the edge.
    task automatic step(input logic r, f, v, input logic [7:0] d, input logic rd);
        reset_i = r; flush_i = f; valid_i = v; data_i = d; ready_i = rd;
        @(negedge clk_i);
        if (r || f) begin
            sbq.delete();
        end else begin
            if (valid_o && ready_i) begin
                if (sbq.size() == 0) chk("sb_read_when_empty", 32'(valid_o), 32'(0));
                else chk("sb_data", 32'(data_o), 32'(sbq.pop_front()));
            end
            if (valid_i && ready_o) sbq.push_back(data_i);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;

        //   rst fl v  data  rd | cnt vo ro af ae cd dout
        add(1, 0, 0, 8'h00, 0,  0, 0, 1, 0, 1, 0, 8'h00);
        add(0, 0, 0, 8'h00, 0,  0, 0, 1, 0, 1, 0, 8'h00);
        add(0, 0, 1, 8'hA5, 0,  1, 1, 1, 0, 1, 1, 8'hA5);
        add(0, 0, 0, 8'h00, 1,  0, 0, 1, 0, 1, 0, 8'h00);
        add(0, 0, 1, 8'h01, 0,  1, 1, 1, 0, 1, 1, 8'h01);
        add(0, 0, 1, 8'h02, 0,  2, 1, 1, 0, 0, 1, 8'h01);
        add(0, 0, 1, 8'h03, 0,  3, 1, 1, 1, 0, 1, 8'h01);
        add(0, 0, 1, 8'h04, 0,  4, 1, 0, 1, 0, 1, 8'h01);
        add(0, 0, 1, 8'h05, 0,  4, 1, 0, 1, 0, 1, 8'h01);
        add(0, 0, 1, 8'h05, 1,  3, 1, 1, 1, 0, 1, 8'h02);
        add(0, 0, 1, 8'h05, 0,  4, 1, 0, 1, 0, 1, 8'h02);
        add(0, 0, 0, 8'h00, 1,  3, 1, 1, 1, 0, 1, 8'h03);
        add(0, 0, 0, 8'h00, 1,  2, 1, 1, 0, 0, 1, 8'h04);
        add(0, 0, 0, 8'h00, 1,  1, 1, 1, 0, 1, 1, 8'h05);
        add(0, 0, 0, 8'h00, 1,  0, 0, 1, 0, 1, 0, 8'h00);
        add(0, 0, 1, 8'h10, 0,  1, 1, 1, 0, 1, 1, 8'h10);
        add(0, 0, 1, 8'h11, 0,  2, 1, 1, 0, 0, 1, 8'h10);
        add(0, 0, 1, 8'h12, 0,  3, 1, 1, 1, 0, 1, 8'h10);
        add(0, 0, 0, 8'h00, 1,  2, 1, 1, 0, 0, 1, 8'h11);
        add(0, 0, 1, 8'h12, 0,  3, 1, 1, 1, 0, 1, 8'h11);
        add(0, 1, 1, 8'h13, 1,  0, 0, 1, 0, 1, 0, 8'h00);
        add(0, 0, 1, 8'h7E, 0,  1, 1, 1, 0, 1, 1, 8'h7E);
        add(0, 0, 0, 8'h00, 1,  0, 0, 1, 0, 1, 0, 8'h00);
        add(0, 0, 1, 8'h20, 0,  1, 1, 1, 0, 1, 1, 8'h20);
        add(1, 0, 1, 8'h21, 1,  0, 0, 1, 0, 1, 0, 8'h00);
        add(0, 0, 0, 8'h00, 0,  0, 0, 1, 0, 1, 0, 8'h00);

        step(1, 0, 0, 8'h00, 0);
`ifdef FIFO_1R1W_FLOW_OVF_EN
        chk("reset_overflow", 32'(overflow_o), 32'(0));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].v, vecs[i].d, vecs[i].rd);
            chk($sformatf("v%0d_count", i), 32'(count_o), 32'(vecs[i].c));
            chk($sformatf("v%0d_valid_o", i), 32'(valid_o), 32'(vecs[i].vo));
            chk($sformatf("v%0d_ready_o", i), 32'(ready_o), 32'(vecs[i].ro));
            chk($sformatf("v%0d_almost_full", i), 32'(almost_full_o), 32'(vecs[i].af));
            chk($sformatf("v%0d_almost_empty", i), 32'(almost_empty_o), 32'(vecs[i].ae));
            if (vecs[i].cd) chk($sformatf("v%0d_data_o", i), 32'(data_o), 32'(vecs[i].dout));
        end

        // Steady streaming at occupancy 2 across several pointer wraps.
        step(0, 0, 1, 8'h40, 0);
        step(0, 0, 1, 8'h41, 0);
        chk("stream_prefill_count", 32'(count_o), 32'(2));
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 8'(8'h42 + i), 1);
            chk($sformatf("stream%0d_count", i), 32'(count_o), 32'(2));
        end
        step(0, 0, 0, 8'h00, 1);
        chk("stream_head", 32'(data_o), 32'(8'h4B));
        step(0, 0, 0, 8'h00, 1);
        chk("stream_drained", 32'(count_o), 32'(0));
        chk("stream_sb_empty", 32'(sbq.size()), 32'(0));

        // Hold stability: head must not change while the consumer stalls.
        step(0, 0, 1, 8'h55, 0);
        step(0, 0, 1, 8'h66, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 8'h77, 0);
            chk($sformatf("hold%0d_data", i), 32'(data_o), 32'(8'h55));
        end
        step(0, 1, 0, 8'h00, 0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 300; i++) begin
            step(0, ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                 8'($urandom), 1'($urandom_range(0, 1)));
            chk($sformatf("rnd%0d_count", i), 32'(count_o), 32'(sbq.size()));
            chk($sformatf("rnd%0d_valid", i), 32'(valid_o), 32'(sbq.size() != 0));
            chk($sformatf("rnd%0d_ready", i), 32'(ready_o), 32'(sbq.size() != 4));
        end

`ifdef FIFO_1R1W_FLOW_OVF_EN
        step(1, 0, 0, 8'h00, 0);
        chk("ovf_after_reset", 32'(overflow_o), 32'(0));
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(i), 0);
        chk("ovf_not_yet", 32'(overflow_o), 32'(0));
        step(0, 0, 1, 8'hEE, 0);
        chk("ovf_set", 32'(overflow_o), 32'(1));
        step(0, 1, 0, 8'h00, 0);
        chk("ovf_after_flush", 32'(overflow_o), 32'(1));
        step(0, 0, 0, 8'h00, 0);
        chk("ovf_held", 32'(overflow_o), 32'(1));
        step(1, 0, 0, 8'h00, 0);
        chk("ovf_cleared", 32'(overflow_o), 32'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
